// File: rtl/out_port_uart_tx.sv
// Streams every change of the processor's out_port as UART 8N1 frames through a capture FIFO.
// Define OUT_UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module out_port_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    port_data,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_TC = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

`ifdef OUT_UART_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t          state, state_next;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [7:0]      last_val, shreg, shreg_next;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic            parity_q, parity_next;
    logic            baud_tc, push_req, push, pop, tx_d;

    assign baud_tc   = (baud_cnt == BAUD_TC);
    assign push_req  = (port_data != last_val);
    assign fifo_full = (fifo_count == DEPTH_C);
    assign pop       = (state == IDLE) && (fifo_count != '0);
    // A full FIFO still accepts a value on the edge the head is popped.
    assign push      = push_req && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (pop) state_next = START;
            START:   if (baud_tc) state_next = DATA;
            DATA:    if (baud_tc && bit_idx == 3'd7) state_next = AFTER_DATA;
            PARITY:  if (baud_tc) state_next = STOP;
            STOP:    if (baud_tc) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // tx is computed from the next state so the line changes on the same edge as the FSM.
    always_comb begin
        busy        = (state != IDLE);
        shreg_next  = shreg;
        parity_next = parity_q;
        if (pop) begin
            shreg_next  = mem[rd_ptr];
            parity_next = ^mem[rd_ptr];
        end else if (state == DATA && baud_tc) begin
            shreg_next = {1'b0, shreg[7:1]};
        end
        unique case (state_next)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_next[0];
            PARITY:  tx_d = parity_next;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= port_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx         <= 1'b1;
            shreg      <= '0;
            parity_q   <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            last_val   <= '0;
        end else begin
            tx       <= tx_d;
            shreg    <= shreg_next;
            parity_q <= parity_next;
            baud_cnt <= (state == IDLE || baud_tc) ? '0 : baud_cnt + 1'b1;
            if (pop)                        bit_idx <= '0;
            else if (state == DATA && baud_tc) bit_idx <= bit_idx + 1'b1;
            if (push_req)           last_val <= port_data;
            if (push_req && !push)  overflow <= 1'b1;
            if (push)               wr_ptr   <= wr_ptr + 1'b1;
            if (pop)                rd_ptr   <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_out_port_uart_tx.sv
// Bench for out_port_uart_tx: queue-based reference model predicts frames and status,
// a line monitor decodes tx and checks each frame against the scoreboard.
module tb_out_port_uart_tx;
  localparam int C = 4;
  localparam int D = 4;
`ifdef OUT_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] port_data = 8'h00;
  logic       tx, busy, fifo_full, overflow;
  logic [2:0] fifo_count;

  out_port_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .port_data(port_data), .tx(tx), .busy(busy),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; int cyc; } exp_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model: pending-byte queue plus remaining-busy-cycles counter.
  logic [7:0] m_q[$];
  exp_t       exp_q[$];
  logic [7:0] m_last = 8'h00;
  int         m_rem = 0;
  bit         m_ovf = 0;
  bit         m_rst_edge = 0;
  bit         chk_en = 0;

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    m_rst_edge = reset;
    if (reset) begin
      m_q.delete();
      exp_q.delete();
      m_last = 8'h00;
      m_rem  = 0;
      m_ovf  = 0;
      chk_en = 1;
    end else begin
      if (m_rem > 0) m_rem--;
      else if (m_q.size() > 0) begin
        e.data = m_q.pop_front();
        e.cyc  = cyc;
        exp_q.push_back(e);
        m_rem = FRAME;
      end
      if (port_data != m_last) begin
        m_last = port_data;
        if (m_q.size() < D) m_q.push_back(port_data);
        else m_ovf = 1;
      end
    end
  end

  // Per-cycle status against the model.
  always @(negedge clk) begin
    logic [5:0] exp_s, act_s;
    if (chk_en) begin
      exp_s = {m_rem > 0, 3'(m_q.size()), m_q.size() == D, m_ovf};
      act_s = {busy, fifo_count, fifo_full, overflow};
      n_cmp++;
      if (act_s !== exp_s) begin
        n_bad++;
        $display("FAIL status cyc=%0d busy/cnt/full/ovf actual=%b required=%b", cyc, act_s, exp_s);
      end
      if (m_rst_edge) begin
        n_cmp++;
        if (tx !== 1'b1) begin
          n_bad++;
          $display("FAIL tx_after_reset cyc=%0d actual=%b required=1", cyc, tx);
        end
      end
    end
  end

  // Line monitor: decode each frame and pop the scoreboard.
  initial begin
    logic [FRAME-1:0] smp;
    logic [7:0]       got;
    exp_t             e;
    bit               have, aborted, stable, ok;
    wait (chk_en);
    forever begin
      @(negedge clk);
      if (!m_rst_edge && tx === 1'b0) begin
        have = exp_q.size() > 0;
        n_cmp++;
        if (!have) begin
          n_bad++;
          $display("FAIL unexpected_frame cyc=%0d actual=start_bit required=idle", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc) begin
            n_bad++;
            $display("FAIL start_time data=%h actual=%0d required=%0d", e.data, cyc, e.cyc);
          end
        end
        aborted = 0;
        smp = '0;
        smp[0] = tx;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          if (m_rst_edge) begin aborted = 1; break; end
          smp[i] = tx;
        end
        if (have && !aborted) begin
          stable = 1;
          for (int b = 0; b < NB; b++)
            for (int j = 0; j < C; j++)
              if (smp[b*C+j] !== smp[b*C]) stable = 0;
          for (int k = 0; k < 8; k++) got[k] = smp[(k+1)*C];
          ok = stable && smp[0] == 1'b0 && smp[(NB-1)*C] == 1'b1 && got == e.data;
`ifdef OUT_UART_PARITY_EN
          ok = ok && (smp[9*C] == ^e.data);
`endif
          n_cmp++;
          if (!ok) begin
            n_bad++;
            $display("FAIL frame cyc=%0d actual data=%h stable=%b start=%b stop=%b required data=%h stable=1 start=0 stop=1",
                     cyc, got, stable, smp[0], smp[(NB-1)*C], e.data);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until_rem(input int target, input int need_full, input string name);
    int t = 0;
    while (!(m_rem == target && (need_full == 0 || m_q.size() == D)) && t < 500) begin
      step(1);
      t++;
    end
    n_cmp++;
    if (t >= 500) begin
      n_bad++;
      $display("FAIL %s_timeout actual=%0d cycles required<500", name, t);
    end
  endtask

  initial begin
    logic [7:0] burst[6];
    int t;
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    reset = 1'b1;
    port_data = 8'h00;
    step(3);
    reset = 1'b0;
    step(10);
    port_data = 8'hA5; step(60);
    port_data = 8'h07; step(60);
    port_data = 8'h3C; step(250);
    foreach (burst[i]) begin
      port_data = burst[i];
      step(1);
    end
    step(6 * FRAME);

    // Full FIFO with a push on the popping edge.
    reset = 1'b1; step(2); reset = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      port_data = 8'(v);
      step(1);
    end
    wait_until_rem(0, 1, "full_pop");
    port_data = 8'h06;
    step(1);
    n_cmp++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL full_pop actual cnt=%0d ovf=%b required cnt=4 ovf=0", fifo_count, overflow);
    end
    step(6 * FRAME);

    // Reset during data bit 3 with two entries queued.
    port_data = 8'h0A; step(1);
    port_data = 8'h0B; step(1);
    port_data = 8'h0C; step(1);
    wait_until_rem(FRAME - 18, 0, "mid_frame");
    reset = 1'b1; step(1); reset = 1'b0;
    step(150);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) port_data = 8'($urandom_range(0, 255));
      step(1);
    end

    t = 0;
    while ((m_rem != 0 || m_q.size() != 0) && t < 3000) begin
      step(1);
      t++;
    end
    step(3);
    n_cmp++;
    if (exp_q.size() != 0 || t >= 3000) begin
      n_bad++;
      $display("FAIL drain actual pending=%0d wait=%0d required pending=0", exp_q.size(), t);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
